// File: rtl/alu_result_checker_pkg.sv
// Shared widths, FSM state type and counter helper for the ALU result checker.
`include "prj_definition.v"

package alu_result_checker_pkg;

    localparam int unsigned DataWidth = `DATA_INDEX_LIMIT + 1;
    localparam int unsigned OprnWidth = `ALU_OPRN_INDEX_LIMIT + 1;
    localparam logic [15:0] CntMax    = 16'hFFFF;

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StCompare,
        StReport
`ifdef ALU_CHK_HALT_ON_ERR_EN
        , StHalt
`endif
    } state_e;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == CntMax) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/alu_ref_model.sv
// Combinational reference ALU: expected result, expected zero flag and opcode validity.
`include "prj_definition.v"

module alu_ref_model
    import alu_result_checker_pkg::*;
(
    input  logic [DataWidth-1:0] OP1,
    input  logic [DataWidth-1:0] OP2,
    input  logic [OprnWidth-1:0] OPRN,
    output logic [DataWidth-1:0] EXP,
    output logic                 EXP_ZERO,
    output logic                 VALID
);

    always_comb begin
        EXP   = '0;
        VALID = 1'b1;
        case (OPRN)
            `ALU_OPRN_ADD: EXP = OP1 + OP2;
            `ALU_OPRN_SUB: EXP = OP1 - OP2;
            `ALU_OPRN_MUL: EXP = OP1 * OP2;
            // Oversized shift amounts flush the result to zero.
            `ALU_OPRN_SRL: EXP = (OP2 >= DataWidth) ? '0 : (OP1 >> OP2);
            `ALU_OPRN_SLL: EXP = (OP2 >= DataWidth) ? '0 : (OP1 << OP2);
            `ALU_OPRN_AND: EXP = OP1 & OP2;
            `ALU_OPRN_OR:  EXP = OP1 | OP2;
            `ALU_OPRN_NOR: EXP = ~(OP1 | OP2);
            `ALU_OPRN_SLT: EXP = {{(DataWidth-1){1'b0}}, ($signed(OP1) < $signed(OP2))};
            default:       VALID = 1'b0;
        endcase
        EXP_ZERO = (EXP == '0);
    end

endmodule

// File: rtl/prj_definition.v
// Shared project definitions: data/opcode index limits and ALU opcode encodings.
`ifndef PRJ_DEFINITION_V
`define PRJ_DEFINITION_V

`define DATA_INDEX_LIMIT      31
`define ALU_OPRN_INDEX_LIMIT  5

`define ALU_OPRN_ADD  6'h01
`define ALU_OPRN_SUB  6'h02
`define ALU_OPRN_MUL  6'h03
`define ALU_OPRN_SRL  6'h04
`define ALU_OPRN_SLL  6'h05
`define ALU_OPRN_AND  6'h06
`define ALU_OPRN_OR   6'h07
`define ALU_OPRN_NOR  6'h08
`define ALU_OPRN_SLT  6'h09

`endif

// File: rtl/alu_result_checker.sv
// Checks an ALU result against a latched-operand reference after SETTLE_CYC cycles.
// Define ALU_CHK_HALT_ON_ERR_EN to park the FSM in HALT after a failing check.
module alu_result_checker
    import alu_result_checker_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic [DataWidth-1:0] OP1,
    input  logic [DataWidth-1:0] OP2,
    input  logic [OprnWidth-1:0] OPRN,
    input  logic [DataWidth-1:0] ALU_OUT,
    input  logic                 ALU_ZERO,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 PASS,
    output logic [DataWidth-1:0] EXP_OUT,
    output logic [15:0]          CHK_CNT,
    output logic [15:0]          ERR_CNT
);

    state_e                 state;
    logic [3:0]             settle_cnt;
    logic [DataWidth-1:0]   op1_q;
    logic [DataWidth-1:0]   op2_q;
    logic [OprnWidth-1:0]   oprn_q;
    logic [DataWidth-1:0]   exp;
    logic                   exp_zero;
    logic                   exp_valid;
    logic                   match;

    alu_ref_model u_ref (
        .OP1      (op1_q),
        .OP2      (op2_q),
        .OPRN     (oprn_q),
        .EXP      (exp),
        .EXP_ZERO (exp_zero),
        .VALID    (exp_valid)
    );

    assign match = (ALU_OUT == exp) && (ALU_ZERO == exp_zero);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= StIdle;
            settle_cnt <= '0;
            op1_q      <= '0;
            op2_q      <= '0;
            oprn_q     <= '0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            PASS       <= 1'b0;
            EXP_OUT    <= '0;
            CHK_CNT    <= '0;
            ERR_CNT    <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (START) begin
                        op1_q      <= OP1;
                        op2_q      <= OP2;
                        oprn_q     <= OPRN;
                        settle_cnt <= '0;
                        BUSY       <= 1'b1;
                        state      <= StSettle;
                    end
                end
                StSettle: begin
                    if (settle_cnt == 4'(SETTLE_CYC - 1)) begin
                        settle_cnt <= '0;
                        state      <= StCompare;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                StCompare: begin
                    // Verdict and counters become visible together with DONE in REPORT.
                    DONE  <= 1'b1;
                    state <= StReport;
                    if (exp_valid) begin
                        PASS    <= match;
                        EXP_OUT <= exp;
                        CHK_CNT <= sat_inc(CHK_CNT);
                        if (!match) begin
                            ERR_CNT <= sat_inc(ERR_CNT);
                        end
                    end else begin
                        PASS    <= 1'b1;
                        EXP_OUT <= '0;
                    end
                end
                StReport: begin
                    DONE <= 1'b0;
`ifdef ALU_CHK_HALT_ON_ERR_EN
                    if (!PASS) begin
                        state <= StHalt;
                    end else begin
                        BUSY  <= 1'b0;
                        state <= StIdle;
                    end
`else
                    BUSY  <= 1'b0;
                    state <= StIdle;
`endif
                end
`ifdef ALU_CHK_HALT_ON_ERR_EN
                StHalt: begin
                    BUSY <= 1'b1;
                end
`endif
                default: begin
                    BUSY  <= 1'b0;
                    DONE  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_result_checker.sv
// Self-checking bench for alu_result_checker: vector table, hand sequences and random checks.
module tb_alu_result_checker;

    localparam int unsigned SETTLE = 2;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        START = 1'b0;
    logic [31:0] OP1 = '0;
    logic [31:0] OP2 = '0;
    logic [5:0]  OPRN = '0;
    logic [31:0] ALU_OUT = '0;
    logic        ALU_ZERO = 1'b0;
    logic        BUSY;
    logic        DONE;
    logic        PASS;
    logic [31:0] EXP_OUT;
    logic [15:0] CHK_CNT;
    logic [15:0] ERR_CNT;

    int n_run = 0;
    int n_fail = 0;
    int m_chk = 0;
    int m_err = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  op;
        logic [31:0] aout;
        logic        az;
        logic        want_pass;
        logic [31:0] want_exp;
        logic        want_valid;
    } vec_t;

    vec_t vecs[18];

    logic [31:0] r_a, r_b, r_e, r_aout;
    logic [5:0]  r_op;
    bit          r_v, r_az, r_wp;
    int          dones;

    alu_result_checker #(.SETTLE_CYC(SETTLE)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .START    (START),
        .OP1      (OP1),
        .OP2      (OP2),
        .OPRN     (OPRN),
        .ALU_OUT  (ALU_OUT),
        .ALU_ZERO (ALU_ZERO),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .PASS     (PASS),
        .EXP_OUT  (EXP_OUT),
        .CHK_CNT  (CHK_CNT),
        .ERR_CNT  (ERR_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_run++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, got, want);
        end
    endtask

    // Reference ALU from the opcode definitions, using 64-bit arithmetic then wrapping.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input logic [5:0] op, output logic [31:0] e, output bit v);
        longint unsigned la = 64'(a);
        longint unsigned lb = 64'(b);
        int              sa = int'(a);
        int              sb = int'(b);
        v = 1'b1;
        e = '0;
        case (op)
            6'd1: e = 32'(la + lb);
            6'd2: e = 32'(la - lb);
            6'd3: e = 32'(la * lb);
            6'd4: e = (lb >= 32) ? 32'd0 : 32'(la / (64'd1 << lb));
            6'd5: e = (lb >= 32) ? 32'd0 : 32'(la * (64'd1 << lb));
            6'd6: e = a & b;
            6'd7: e = a | b;
            6'd8: e = ~(a | b);
            6'd9: e = (sa < sb) ? 32'd1 : 32'd0;
            default: v = 1'b0;
        endcase
    endfunction

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b0;
        START = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        m_chk = 0;
        m_err = 0;
    endtask

    task automatic apply(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] op, input logic [31:0] aout, input logic az,
                         input logic want_pass, input logic [31:0] want_exp,
                         input logic want_valid, input bit scramble, input bit poke);
        int lat = 0;
        int halt_dones = 0;
        @(negedge CLK);
        OP1 = a;
        OP2 = b;
        OPRN = op;
        ALU_OUT = aout;
        ALU_ZERO = az;
        START = 1'b1;
        for (int n = 1; n <= int'(SETTLE) + 8; n++) begin
            @(negedge CLK);
            if (n == 1) begin
                START = 1'b0;
                chk({name, ".busy"}, 32'(BUSY), 32'd1);
                if (scramble) begin
                    OP1 = $urandom;
                    OP2 = $urandom;
                    OPRN = 6'($urandom);
                end
            end
            if (poke && n == 2) START = 1'b1;
            if (poke && n == 3) START = 1'b0;
            if (DONE) begin
                lat = n;
                break;
            end
        end
        START = 1'b0;
        chk({name, ".latency"}, 32'(lat), 32'(SETTLE + 2));
        if (lat != 0) begin
            if (want_valid) begin
                if (m_chk < 65535) m_chk++;
                if (!want_pass && m_err < 65535) m_err++;
            end
            chk({name, ".pass"}, 32'(PASS), 32'(want_pass));
            chk({name, ".exp_out"}, EXP_OUT, want_exp);
            chk({name, ".chk_cnt"}, 32'(CHK_CNT), 32'(m_chk));
            chk({name, ".err_cnt"}, 32'(ERR_CNT), 32'(m_err));
            @(negedge CLK);
            chk({name, ".done_pulse"}, 32'(DONE), 32'd0);
`ifdef ALU_CHK_HALT_ON_ERR_EN
            if (!want_pass) begin
                chk({name, ".halt_busy"}, 32'(BUSY), 32'd1);
                START = 1'b1;
                @(negedge CLK);
                START = 1'b0;
                repeat (SETTLE + 4) begin
                    @(negedge CLK);
                    if (DONE) halt_dones++;
                end
                chk({name, ".halt_no_done"}, 32'(halt_dones), 32'd0);
                chk({name, ".halt_busy_held"}, 32'(BUSY), 32'd1);
                do_reset();
            end else begin
                chk({name, ".busy_after"}, 32'(BUSY), 32'd0);
            end
`else
            chk({name, ".busy_after"}, 32'(BUSY), 32'd0);
`endif
        end else begin
            do_reset();
        end
    endtask

    initial begin
        //          a             b             op     aout          az    pass  exp           valid
        vecs[0]  = '{32'd2,        32'd1,        6'd2,  32'd1,        1'b0, 1'b1, 32'd1,        1'b1};
        vecs[1]  = '{32'd100,      32'd79,       6'd2,  32'd21,       1'b0, 1'b1, 32'd21,       1'b1};
        vecs[2]  = '{32'hFFFFFFF4, 32'd15,       6'd1,  32'd3,        1'b0, 1'b1, 32'd3,        1'b1};
        vecs[3]  = '{32'd10,       32'd3,        6'd1,  32'd4,        1'b0, 1'b0, 32'd13,       1'b1};
        vecs[4]  = '{32'd5,        32'd5,        6'd2,  32'd0,        1'b0, 1'b0, 32'd0,        1'b1};
        vecs[5]  = '{32'd9,        32'd9,        6'd12, 32'd123,      1'b0, 1'b1, 32'd0,        1'b0};
        vecs[6]  = '{32'd0,        32'd0,        6'd0,  32'd0,        1'b1, 1'b1, 32'd0,        1'b0};
        vecs[7]  = '{32'hFFFFFFFF, 32'd1,        6'd9,  32'd1,        1'b0, 1'b1, 32'd1,        1'b1};
        vecs[8]  = '{32'd1,        32'hFFFFFFFF, 6'd9,  32'd0,        1'b1, 1'b1, 32'd0,        1'b1};
        vecs[9]  = '{32'h80000000, 32'd32,       6'd4,  32'd0,        1'b1, 1'b1, 32'd0,        1'b1};
        vecs[10] = '{32'h80000000, 32'd31,       6'd4,  32'd1,        1'b0, 1'b1, 32'd1,        1'b1};
        vecs[11] = '{32'd1,        32'd31,       6'd5,  32'h80000000, 1'b0, 1'b1, 32'h80000000, 1'b1};
        vecs[12] = '{32'h12345678, 32'd40,       6'd5,  32'd0,        1'b1, 1'b1, 32'd0,        1'b1};
        vecs[13] = '{32'h10000,    32'h10000,    6'd3,  32'd0,        1'b1, 1'b1, 32'd0,        1'b1};
        vecs[14] = '{32'd0,        32'd0,        6'd8,  32'hFFFFFFFF, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b1};
        vecs[15] = '{32'hF0F0F0F0, 32'hFF00FF00, 6'd6,  32'hF000F000, 1'b0, 1'b1, 32'hF000F000, 1'b1};
        vecs[16] = '{32'hF0F0F0F0, 32'h0F0F0000, 6'd7,  32'hFFFFF0F0, 1'b0, 1'b1, 32'hFFFFF0F0, 1'b1};
        vecs[17] = '{32'd7,        32'd9,        6'd3,  32'd63,       1'b0, 1'b1, 32'd63,       1'b1};

        // Reset state.
        repeat (3) @(negedge CLK);
        chk("rst.busy", 32'(BUSY), 32'd0);
        chk("rst.done", 32'(DONE), 32'd0);
        chk("rst.pass", 32'(PASS), 32'd0);
        chk("rst.exp_out", EXP_OUT, 32'd0);
        chk("rst.chk_cnt", 32'(CHK_CNT), 32'd0);
        chk("rst.err_cnt", 32'(ERR_CNT), 32'd0);
        RST = 1'b1;

        foreach (vecs[i]) begin
            apply($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].aout,
                  vecs[i].az, vecs[i].want_pass, vecs[i].want_exp, vecs[i].want_valid, 0, 0);
        end

        // Operands scrambled during SETTLE must not change the verdict.
        apply("latched", 32'd7, 32'd8, 6'd1, 32'd15, 1'b0, 1'b1, 32'd15, 1'b1, 1, 0);

        // START while busy is ignored: exactly one DONE.
        apply("poke", 32'd6, 32'd3, 6'd2, 32'd3, 1'b0, 1'b1, 32'd3, 1'b1, 0, 1);
        dones = 0;
        repeat (SETTLE + 4) begin
            @(negedge CLK);
            if (DONE) dones++;
        end
        chk("poke.extra_done", 32'(dones), 32'd0);

        // Reset during SETTLE aborts the check and clears everything at once.
        @(negedge CLK);
        OP1 = 32'd3; OP2 = 32'd4; OPRN = 6'd1; ALU_OUT = 32'd7; ALU_ZERO = 1'b0;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        chk("abort.pre_cnt_nonzero", 32'(CHK_CNT != 16'd0), 32'd1);
        #2 RST = 1'b0;
        #1;
        chk("abort.busy", 32'(BUSY), 32'd0);
        chk("abort.done", 32'(DONE), 32'd0);
        chk("abort.pass", 32'(PASS), 32'd0);
        chk("abort.exp_out", EXP_OUT, 32'd0);
        chk("abort.chk_cnt", 32'(CHK_CNT), 32'd0);
        chk("abort.err_cnt", 32'(ERR_CNT), 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        m_chk = 0;
        m_err = 0;
        dones = 0;
        repeat (SETTLE + 4) begin
            @(negedge CLK);
            if (DONE) dones++;
        end
        chk("abort.no_done", 32'(dones), 32'd0);
        chk("abort.cnt_after", 32'(CHK_CNT), 32'd0);

        // Randomised checks against the reference model.
        for (int i = 0; i < 150; i++) begin
            r_op = 6'($urandom_range(0, 12));
            r_a = $urandom;
            r_b = (r_op == 6'd4 || r_op == 6'd5) ? 32'($urandom_range(0, 40)) : $urandom;
            if ($urandom_range(0, 7) == 0) r_b = r_a;
            model(r_a, r_b, r_op, r_e, r_v);
            r_aout = r_v ? r_e : $urandom;
            r_az = r_v ? (r_e == 32'd0) : 1'($urandom);
`ifndef ALU_CHK_HALT_ON_ERR_EN
            case ($urandom_range(0, 3))
                0: r_aout = r_aout ^ (32'd1 << $urandom_range(0, 31));
                1: r_az = ~r_az;
                default: ;
            endcase
`endif
            r_wp = !r_v || (r_aout == r_e && r_az == (r_e == 32'd0));
            apply($sformatf("rnd%0d", i), r_a, r_b, r_op, r_aout, r_az, r_wp,
                  r_v ? r_e : 32'd0, r_v, 1'($urandom_range(0, 1)), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_result_checker.md
ALU_RESULT_CHECKER -- requirements
Module: alu_result_checker

Interface
REQ-001 SHALL have parameter: SETTLE_CYC, 2, number of CLK cycles between START and sampling ALU_OUT/ALU_ZERO (legal 1..15).
REQ-002 SHALL have port: CLK  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: RST  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: START  input  1  one-cycle request to check the operation currently applied to the ALU.
REQ-005 SHALL have port: OP1  input  `DATA_INDEX_LIMIT+1  operand 1 as driven to ALU.
REQ-006 SHALL have port: OP2  input  `DATA_INDEX_LIMIT+1  operand 2 as driven to ALU.
REQ-007 SHALL have port: OPRN  input  `ALU_OPRN_INDEX_LIMIT+1  operation code as driven to ALU.
REQ-008 SHALL have port: ALU_OUT  input  `DATA_INDEX_LIMIT+1  ALU result under check.
REQ-009 SHALL have port: ALU_ZERO  input  1  ALU zero flag under check.
REQ-010 SHALL have port: BUSY  output  1  high from the cycle after accepted START until DONE.
REQ-011 SHALL have port: DONE  output  1  one-cycle pulse, verdict valid.
REQ-012 SHALL have port: PASS  output  1  verdict of last check, held until next DONE.
REQ-013 SHALL have port: EXP_OUT  output  `DATA_INDEX_LIMIT+1  expected result of last check, held.
REQ-014 SHALL have port: CHK_CNT  output  16  number of compared checks.
REQ-015 SHALL have port: ERR_CNT  output  16  number of failed checks.

Function
REQ-016 SHALL implement FSM IDLE -> SETTLE -> COMPARE -> REPORT -> IDLE (plus HALT, see REQ-030).
REQ-017 IDLE: START=1 SHALL latch OP1, OP2, OPRN and enter SETTLE; START in any other state SHALL be ignored.
REQ-018 SETTLE SHALL count SETTLE_CYC cycles, then enter COMPARE; ALU_OUT/ALU_ZERO SHALL be sampled on the COMPARE cycle.
REQ-019 Expected result from latched operands: 1 add, 2 sub, 3 mul (low 32 bits), 4 shift right logical by OP2, 5 shift left by OP2, 6 and, 7 or, 8 nor, 9 set-less-than signed (1/0); shift amount >=32 gives 0; all arithmetic modulo 2^32.
REQ-020 Expected zero SHALL be 1 iff expected result is 0.
REQ-021 PASS SHALL be 1 iff ALU_OUT equals expected result and ALU_ZERO equals expected zero.
REQ-022 Unrecognised OPRN (0, 10..63) SHALL yield PASS=1, EXP_OUT=0, and no counter update.
REQ-023 REPORT SHALL pulse DONE for exactly one cycle; PASS, EXP_OUT, counters update in the same cycle.
REQ-024 CHK_CNT and ERR_CNT SHALL saturate at 16'hFFFF.
REQ-025 Latency START to DONE SHALL be SETTLE_CYC+2 cycles; next START accepted the cycle after DONE.
REQ-026 Operand/ALU input changes during SETTLE SHALL NOT affect the expected result (latched copy used).

Reset
REQ-027 RST low SHALL immediately force state IDLE, BUSY=0, DONE=0, PASS=0, EXP_OUT=0, CHK_CNT=0, ERR_CNT=0, settle counter 0.
REQ-028 Reset mid-check SHALL abort without DONE and without counter update.

Configuration
REQ-029 Macro ALU_CHK_HALT_ON_ERR_EN SHALL select halt-on-error behaviour.
REQ-030 Defined: a failing check SHALL enter HALT after REPORT; HALT holds BUSY=1, ignores START, exits only by reset. Undefined: HALT state absent; FSM always returns to IDLE.

Structure
REQ-031 Opcode constants (ADD=1 .. SLT=9), data/opcode index limits SHALL reside in shared prj_definition.v.
REQ-032 Expected-value computation SHALL be a combinational sub-module alu_ref_model (inputs OP1, OP2, OPRN; outputs EXP, EXP_ZERO, VALID).

Verification
REQ-033 OP1=2, OP2=1, OPRN=2, ALU_OUT=1, ZERO=0, START -> DONE after 4 cycles, PASS=1, EXP_OUT=1, CHK_CNT=1.
REQ-034 OP1=100, OP2=79, OPRN=2, ALU_OUT=21; then OP1=-12, OP2=15, OPRN=1, ALU_OUT=3 -> both PASS=1, CHK_CNT=2, ERR_CNT=0.
REQ-035 OP1=10, OP2=3, OPRN=1, ALU_OUT=4 -> PASS=0, EXP_OUT=13, ERR_CNT=1; with halt macro BUSY stays 1, later START ignored.
REQ-036 OP1=5, OP2=5, OPRN=2, ALU_OUT=0, ALU_ZERO=0 -> PASS=0 (zero-flag mismatch).
REQ-037 START then RST low during SETTLE -> no DONE, all outputs 0; START during BUSY -> ignored, single DONE.
REQ-038 OPRN=12 -> PASS=1, EXP_OUT=0, counters unchanged.
